// File: rtl/packet_injector.sv
// packet_injector: CPU-driven AXIS packet source for one switch ingress port.
// Bytes written over the 8-bit Avalon-MM slave are packed into 16-bit words
// and buffered in a FIFO. COMMIT streams the buffered packet with a latched
// tdest, flags the final word with tlast and raises a level interrupt.
//
// state | meaning
// ------+-------------------------------------------------------------
// FILL  | idle; CPU loads bytes, may FLUSH or COMMIT
// SEND  | packet streaming to the switch; CPU data writes are rejected
module packet_injector #(
    parameter int FIFO_DEPTH = 64,
    parameter int DEST_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            writedata,
    input  logic                  write,
    input  logic                  chipselect,
    input  logic [7:0]            address,
    input  logic                  read,
    output logic [7:0]            readdata,
    output logic [15:0]           tx_tdata,
    output logic                  tx_tvalid,
    input  logic                  tx_tready,
    output logic                  tx_tlast,
    output logic [DEST_WIDTH-1:0] tx_tdest,
    output logic                  irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [7:0] ADDR_DATA   = 8'h00;
    localparam logic [7:0] ADDR_DEST   = 8'h01;
    localparam logic [7:0] ADDR_CTRL   = 8'h02;
    localparam logic [7:0] ADDR_COUNT  = 8'h03;
    localparam logic [7:0] ADDR_IRQ_EN = 8'h04;

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [15:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  half;
    logic [7:0]            hi;
    logic [DEST_WIDTH-1:0] dest_reg;
    logic                  irq_en, irq_pend, ovf;

    logic        wr_acc, rd_acc;
    logic        wr_data, wr_dest, wr_ctrl, wr_irq_en;
    logic        commit_req, flush_req, irq_clr_req;
    logic        full, empty, handshake, last_word;
    logic        push, pop, hi_load, half_nxt;
    logic        ovf_set, irq_set, flush_go, latch_dest;
    logic [15:0] push_word;
    logic [31:0] count_w;
    logic [7:0]  count_byte;
    logic [7:0]  status;

    assign wr_acc      = chipselect & write;
    assign rd_acc      = chipselect & read;
    assign wr_data     = wr_acc && (address == ADDR_DATA);
    assign wr_dest     = wr_acc && (address == ADDR_DEST);
    assign wr_ctrl     = wr_acc && (address == ADDR_CTRL);
    assign wr_irq_en   = wr_acc && (address == ADDR_IRQ_EN);
    assign commit_req  = wr_ctrl & writedata[0];
    assign flush_req   = wr_ctrl & writedata[1];
    assign irq_clr_req = wr_ctrl & writedata[2];

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign last_word = (count == CW'(1));

    assign tx_tvalid = (state == SEND);
    assign tx_tdata  = tx_tvalid ? mem[rd_ptr] : 16'h0000;
    assign tx_tlast  = tx_tvalid & last_word;
    assign handshake = tx_tvalid & tx_tready;

    assign count_w    = 32'(count);
    assign count_byte = (count_w < 32'd256) ? count_w[7:0] : 8'hFF;
    assign status     = {3'b000, ovf, irq_pend, half, full, tx_tvalid};

    // Next-state, FIFO push/pop and flag-set decisions
    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        push_word  = 16'h0000;
        pop        = 1'b0;
        hi_load    = 1'b0;
        half_nxt   = half;
        ovf_set    = 1'b0;
        irq_set    = 1'b0;
        flush_go   = 1'b0;
        latch_dest = 1'b0;
        case (state)
            FILL: begin
                if (wr_data) begin
                    if (!half) begin
                        hi_load  = 1'b1;
                        half_nxt = 1'b1;
                    end else begin
                        half_nxt = 1'b0;
                        if (full) begin
                            ovf_set = 1'b1;
                        end else begin
                            push      = 1'b1;
                            push_word = {hi, writedata};
                        end
                    end
                end else if (flush_req) begin
                    // FLUSH beats COMMIT when both bits are written together
                    flush_go = 1'b1;
                    half_nxt = 1'b0;
                end else if (commit_req && (!empty || half)) begin
                    latch_dest = 1'b1;
                    state_nxt  = SEND;
                    half_nxt   = 1'b0;
                    if (half) begin
                        if (full) begin
                            ovf_set = 1'b1;
                        end else begin
                            push      = 1'b1;
                            push_word = {hi, 8'h00};
                        end
                    end
                end
            end
            SEND: begin
                if (wr_data) begin
                    ovf_set = 1'b1;
                end
                if (handshake) begin
                    pop = 1'b1;
                    if (last_word) begin
                        state_nxt = FILL;
                        irq_set   = 1'b1;
                    end
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // FIFO storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || flush_go) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Byte packing, configuration registers and packet destination
    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= 8'h00;
            half     <= 1'b0;
            dest_reg <= '0;
            irq_en   <= 1'b0;
            tx_tdest <= '0;
        end else begin
            half <= half_nxt;
            if (hi_load) begin
                hi <= writedata;
            end
            if (wr_dest) begin
                dest_reg <= writedata[DEST_WIDTH-1:0];
            end
            if (wr_irq_en) begin
                irq_en <= writedata[0];
            end
            if (latch_dest) begin
                tx_tdest <= dest_reg;
            end
        end
    end

    // Sticky flags; a set in the same cycle as IRQ_CLR wins
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf      <= 1'b0;
            irq_pend <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (irq_clr_req) begin
                ovf <= 1'b0;
            end
            if (irq_set) begin
                irq_pend <= 1'b1;
            end else if (irq_clr_req) begin
                irq_pend <= 1'b0;
            end
            irq <= irq_pend & irq_en;
        end
    end

    // Registered read port; sees pre-write values on a same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 8'h00;
        end else if (rd_acc) begin
            case (address)
                ADDR_DATA:   readdata <= status;
                ADDR_DEST:   readdata <= 8'(dest_reg);
                ADDR_COUNT:  readdata <= count_byte;
                ADDR_IRQ_EN: readdata <= {7'b0000000, irq_en};
                default:     readdata <= 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_injector.sv
// Testbench for packet_injector: directed scenarios plus randomized register
// traffic, all compared against a queue-based packet model.
module tb_packet_injector;

    localparam int DEPTH = 64;
    localparam int DW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    writedata;
    logic          write;
    logic          chipselect;
    logic [7:0]    address;
    logic          read;
    logic [7:0]    readdata;
    logic [15:0]   tx_tdata;
    logic          tx_tvalid;
    logic          tx_tready;
    logic          tx_tlast;
    logic [DW-1:0] tx_tdest;
    logic          irq;

    always #5 clk = ~clk;

    packet_injector #(.FIFO_DEPTH(DEPTH), .DEST_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .writedata(writedata), .write(write),
        .chipselect(chipselect), .address(address), .read(read),
        .readdata(readdata), .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid),
        .tx_tready(tx_tready), .tx_tlast(tx_tlast), .tx_tdest(tx_tdest),
        .irq(irq)
    );

    int checks   = 0;
    int failures = 0;

    // reference model: buffered packet as a queue of words plus flags
    logic [15:0]   q[$];
    bit            m_half, m_ovf, m_pend, m_en, m_busy;
    logic [7:0]    m_hi;
    logic [DW-1:0] m_dest, m_tdest;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_half = 0; m_ovf = 0; m_pend = 0; m_en = 0; m_busy = 0;
        m_hi = 8'h00; m_dest = '0; m_tdest = '0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        case (a)
            8'h00: begin
                if (m_busy) m_ovf = 1;
                else if (!m_half) begin m_hi = d; m_half = 1; end
                else begin
                    m_half = 0;
                    if (q.size() == DEPTH) m_ovf = 1;
                    else q.push_back({m_hi, d});
                end
            end
            8'h01: m_dest = d[DW-1:0];
            8'h02: begin
                if (d[2]) begin m_pend = 0; m_ovf = 0; end
                if (!m_busy) begin
                    if (d[1]) begin
                        q.delete();
                        m_half = 0;
                    end else if (d[0] && (q.size() > 0 || m_half)) begin
                        if (m_half) begin
                            if (q.size() == DEPTH) m_ovf = 1;
                            else q.push_back({m_hi, 8'h00});
                            m_half = 0;
                        end
                        m_busy  = 1;
                        m_tdest = m_dest;
                    end
                end
            end
            8'h04: m_en = d[0];
            default: ;
        endcase
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        case (a)
            8'h00:   return {3'b000, m_ovf, m_pend, m_half, (q.size() == DEPTH), m_busy};
            8'h01:   return 8'(m_dest);
            8'h03:   return 8'((q.size() > 255) ? 255 : q.size());
            8'h04:   return {7'b0000000, m_en};
            default: return 8'h00;
        endcase
    endfunction

    // bus tasks start and end on a falling edge
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        chipselect = 1; write = 1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 0; write = 0;
        model_write(a, d);
    endtask

    task automatic rd(input string tag, input logic [7:0] a);
        logic [7:0] exp;
        exp = model_read(a);
        chipselect = 1; read = 1; address = a;
        @(negedge clk);
        chipselect = 0; read = 0;
        chk(tag, 32'(readdata), 32'(exp));
    endtask

    task automatic check_all(input string tag);
        rd({tag, "_status"}, 8'h00);
        rd({tag, "_count"}, 8'h03);
        chk({tag, "_irq"}, 32'(irq), 32'(m_pend & m_en));
    endtask

    // mode 0: random tready, 1: always ready, 2: 1010 pattern
    task automatic drain(input int mode, input int max_beats);
        int   beats = 0;
        int   cyc   = 0;
        logic rdy;
        while (m_busy && beats < max_beats && cyc < 1000) begin
            case (mode)
                0:       rdy = 1'($urandom_range(0, 1));
                1:       rdy = 1'b1;
                default: rdy = (cyc % 2 == 0);
            endcase
            tx_tready = rdy;
            chk("tvalid", 32'(tx_tvalid), 32'(1));
            chk("tdata", 32'(tx_tdata), 32'(q[0]));
            chk("tlast", 32'(tx_tlast), 32'(q.size() == 1));
            chk("tdest", 32'(tx_tdest), 32'(m_tdest));
            @(posedge clk);
            if (rdy) begin
                void'(q.pop_front());
                beats++;
                if (q.size() == 0) begin m_busy = 0; m_pend = 1; end
            end
            cyc++;
            @(negedge clk);
        end
        tx_tready = 0;
        chk("drain_budget", 32'(cyc < 1000), 32'(1));
        if (!m_busy) chk("tvalid_after", 32'(tx_tvalid), 32'(0));
    endtask

    initial begin
        reset = 1; chipselect = 0; write = 0; read = 0;
        address = 8'h00; writedata = 8'h00; tx_tready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;

        chk("rst_tvalid", 32'(tx_tvalid), 32'(0));
        chk("rst_tlast", 32'(tx_tlast), 32'(0));
        chk("rst_tdata", 32'(tx_tdata), 32'(0));
        chk("rst_tdest", 32'(tx_tdest), 32'(0));
        chk("rst_irq", 32'(irq), 32'(0));
        chk("rst_readdata", 32'(readdata), 32'(0));
        check_all("rst");
        rd("rst_dest", 8'h01);

        // two-word packet to dest 2 with irq enabled
        wr(8'h01, 8'h02);
        wr(8'h00, 8'hAA); wr(8'h00, 8'hBB); wr(8'h00, 8'hCC); wr(8'h00, 8'hDD);
        wr(8'h04, 8'h01);
        chk("t1_q0", 32'(q[0]), 32'h0000AABB);
        wr(8'h02, 8'h01);
        drain(1, 100);
        check_all("t1");
        chk("t1_irq_high", 32'(irq), 32'(1));
        wr(8'h02, 8'h04);
        check_all("t1_clr");

        // odd byte count: trailing byte padded with 0x00
        wr(8'h00, 8'h11); wr(8'h00, 8'h22); wr(8'h00, 8'h33);
        rd("t2_half", 8'h00);
        wr(8'h02, 8'h01);
        chk("t2_pad", 32'(q[1]), 32'h00003300);
        drain(1, 100);
        check_all("t2");

        // 4-word packet under 1010 backpressure
        for (int i = 0; i < 8; i++) wr(8'h00, 8'(8'h40 + i));
        wr(8'h02, 8'h01);
        drain(2, 100);
        check_all("t3");
        wr(8'h02, 8'h04);

        // overfill by one word, then send the full buffer
        for (int i = 0; i < 2 * DEPTH + 2; i++) wr(8'h00, 8'($urandom));
        rd("t4_status", 8'h00);
        chk("t4_status_const", 32'(readdata), 32'h12);
        rd("t4_count", 8'h03);
        chk("t4_count_const", 32'(readdata), 32'(DEPTH));
        wr(8'h02, 8'h01);
        drain(0, 1000);
        check_all("t4");
        wr(8'h02, 8'h04);

        // commit on empty FIFO, then flush a partial load
        wr(8'h02, 8'h01);
        chk("t5_idle1", 32'(tx_tvalid), 32'(0));
        @(negedge clk);
        chk("t5_idle2", 32'(tx_tvalid), 32'(0));
        for (int i = 0; i < 6; i++) wr(8'h00, 8'($urandom));
        wr(8'h02, 8'h02);
        check_all("t5");
        chk("t5_no_out", 32'(tx_tvalid), 32'(0));

        // reset in the middle of an 8-word packet
        for (int i = 0; i < 16; i++) wr(8'h00, 8'($urandom));
        wr(8'h04, 8'h01);
        wr(8'h02, 8'h01);
        drain(1, 3);
        reset = 1;
        @(negedge clk);
        reset = 0;
        model_reset();
        chk("t6_tvalid", 32'(tx_tvalid), 32'(0));
        chk("t6_irq", 32'(irq), 32'(0));
        check_all("t6");
        rd("t6_irq_en", 8'h04);

        // randomized register traffic
        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 15);
            if (op < 8)        wr(8'h00, 8'($urandom));
            else if (op == 8)  wr(8'h01, 8'($urandom));
            else if (op == 9)  wr(8'h04, 8'($urandom));
            else if (op == 10) wr(8'h02, 8'($urandom_range(0, 7)));
            else if (op == 11) wr(8'h02, 8'h01);
            else if (op == 12) rd("rnd_rd", 8'($urandom_range(0, 6)));
            else if (op == 13) rd("rnd_rd_hi", 8'($urandom));
            else if (op == 14) drain(0, $urandom_range(1, 4));
            else               check_all("rnd");
        end
        drain(0, 1000);
        check_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
